wca_reg_bank: RTL and testbench



---
 rtl/wca_reg_pkg.sv | 27 ++
 rtl/wca_reg_cell.sv | 42 ++++
 rtl/wca_reg_bank.sv | 73 +++++++
 tb/tb_wca_reg_bank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wca_reg_pkg.sv
// Shared definitions for the wca register bank: write-mode encoding and the
// per-bit mode function used by the register cells and the host-bus model.
package wca_reg_pkg;

    typedef enum logic [1:0] {
        WR_WRITE = 2'd0,
        WR_SET   = 2'd1,
        WR_CLR   = 2'd2,
        WR_TGL   = 2'd3
    } wr_mode_e;

    // The modes are purely bitwise, so a single-bit form serves every width.
    function automatic logic apply_mode(input wr_mode_e mode,
                                        input logic     old_bit,
                                        input logic     op_bit);
        logic r;
        r = op_bit;
        case (mode)
            WR_WRITE: r = op_bit;
            WR_SET:   r = old_bit | op_bit;
            WR_CLR:   r = old_bit & ~op_bit;
            WR_TGL:   r = old_bit ^ op_bit;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wca_reg_cell.sv
// One WIDTH-bit control register: mode-based update, self-clearing pulse bits
// and a one-cycle strobe when a write alters the stored value.
module wca_reg_cell
    import wca_reg_pkg::*;
#(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] PULSE_MASK = '0
) (
    input  logic             Clock,
    input  logic             Aclr,
    input  logic             we,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q,
    output logic             changed
);

    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            nxt[b] = apply_mode(wr_mode_e'(mode), q[b], wdata[b]);
        end
    end

    // Pulse bits only survive a cycle in which this register is written.
    always_ff @(posedge Clock) begin
        if (Aclr) begin
            q       <= RESET_VAL & ~PULSE_MASK;
            changed <= 1'b0;
        end else if (we) begin
            q       <= nxt;
            changed <= (nxt != q);
        end else begin
            q       <= q & ~PULSE_MASK;
            changed <= 1'b0;
        end
    end

endmodule

// File: rtl/wca_reg_bank.sv
// Bank of DEPTH control registers with address-decoded mode writes, a
// registered read port, flattened contents and per-register change strobes.
module wca_reg_bank
    import wca_reg_pkg::*;
#(
    parameter int unsigned      WIDTH      = 16,
    parameter int unsigned      DEPTH      = 8,
    parameter int unsigned      ADDR_W     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] PULSE_MASK = '0
) (
    input  logic                   Clock,
    input  logic                   Aclr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [1:0]             wr_mode,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [DEPTH*WIDTH-1:0] q_flat,
    output logic [DEPTH-1:0]       changed
);

    logic [WIDTH-1:0] q_arr [DEPTH];
    logic [WIDTH-1:0] rd_mux;

    // Exact-match decode: addresses at or beyond DEPTH select no cell.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic we;
        assign we = wr_en && (wr_addr == ADDR_W'(i));

        wca_reg_cell #(
            .WIDTH      (WIDTH),
            .RESET_VAL  (RESET_VAL),
            .PULSE_MASK (PULSE_MASK)
        ) u_cell (
            .Clock   (Clock),
            .Aclr    (Aclr),
            .we      (we),
            .mode    (wr_mode),
            .wdata   (wr_data),
            .q       (q_arr[i]),
            .changed (changed[i])
        );

        assign q_flat[i*WIDTH +: WIDTH] = q_arr[i];
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = q_arr[i];
            end
        end
    end

    // Samples the pre-edge contents, so a same-cycle write reads as old data.
    always_ff @(posedge Clock) begin
        if (Aclr) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_wca_reg_bank.sv
// Directed self-checking bench for wca_reg_bank (DEPTH=6, pulse bit 0);
// read expectations are queued at issue and compared when rd_valid arrives.
module tb_wca_reg_bank;

    logic        Clock   = 1'b0;
    logic        Aclr    = 1'b1;
    logic        wr_en   = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [1:0]  wr_mode = '0;
    logic [15:0] wr_data = '0;
    logic        rd_en   = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [95:0] q_flat;
    logic [5:0]  changed;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_reg [6];

    wca_reg_bank #(
        .WIDTH      (16),
        .DEPTH      (6),
        .ADDR_W     (3),
        .RESET_VAL  (16'hA5A5),
        .PULSE_MASK (16'h0001)
    ) dut (
        .Clock    (Clock),
        .Aclr     (Aclr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mode  (wr_mode),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .q_flat   (q_flat),
        .changed  (changed)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), 32'(q_flat[i*16 +: 16]), 32'(exp_reg[i]));
        end
    endtask

    task automatic issue_rd(input logic [2:0] a, input logic [15:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
    endtask

    // One clock edge, then the read port is scored against the queue.
    task automatic tick();
        logic ev;
        ev = rd_en && !Aclr;
        if (Aclr) exp_q.delete();
        @(posedge Clock);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) begin
            if (exp_q.size() == 0) begin
                chk("rd_queue_empty", 32'd1, 32'd0);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic do_wr(input logic [2:0] a, input logic [1:0] m, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_mode = m;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        // Reset, including a write and read colliding with Aclr
        tick();
        wr_en = 1'b1; wr_addr = 3'd2; wr_mode = 2'd0; wr_data = 16'hFFFF;
        rd_en = 1'b1; rd_addr = 3'd2;
        tick();
        for (int i = 0; i < 6; i++) exp_reg[i] = 16'hA5A4;
        chk_regs("reset");
        chk("reset_changed", 32'(changed), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        Aclr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        tick();
        chk_regs("post_reset");
        chk("post_reset_changed", 32'(changed), 32'd0);

        // Mode sequence on register 3
        do_wr(3'd3, 2'd0, 16'h1234); exp_reg[3] = 16'h1234;
        chk_regs("wr"); chk("wr_changed", 32'(changed), 32'h08);
        do_wr(3'd3, 2'd1, 16'h00F0); exp_reg[3] = 16'h12F4;
        chk_regs("set"); chk("set_changed", 32'(changed), 32'h08);
        do_wr(3'd3, 2'd1, 16'h00F0);
        chk_regs("set_again"); chk("set_again_changed", 32'(changed), 32'h00);
        do_wr(3'd3, 2'd2, 16'h0204); exp_reg[3] = 16'h10F0;
        chk_regs("clr"); chk("clr_changed", 32'(changed), 32'h08);
        do_wr(3'd3, 2'd3, 16'hFFFF); exp_reg[3] = 16'hEF0F;
        chk_regs("tgl"); chk("tgl_changed", 32'(changed), 32'h08);

        // Read during write returns old data; next read sees the new value
        issue_rd(3'd3, 16'hEF0F);
        do_wr(3'd3, 2'd0, 16'h5555); rd_en = 1'b0; exp_reg[3] = 16'h5555;
        chk_regs("rdw"); chk("rdw_changed", 32'(changed), 32'h08);
        issue_rd(3'd3, 16'h5555);
        tick(); rd_en = 1'b0; exp_reg[3] = 16'h5554;
        chk_regs("rd_new"); chk("selfclr_changed", 32'(changed), 32'h00);

        // Pulse bit on register 1
        do_wr(3'd1, 2'd1, 16'h0001); exp_reg[1] = 16'hA5A5;
        chk_regs("pulse_set"); chk("pulse_set_changed", 32'(changed), 32'h02);
        tick(); exp_reg[1] = 16'hA5A4;
        chk_regs("pulse_clr"); chk("pulse_clr_changed", 32'(changed), 32'h00);
        do_wr(3'd1, 2'd1, 16'h0001); exp_reg[1] = 16'hA5A5;
        chk_regs("pulse2_a"); chk("pulse2_a_changed", 32'(changed), 32'h02);
        do_wr(3'd1, 2'd1, 16'h0001);
        chk_regs("pulse2_b"); chk("pulse2_b_changed", 32'(changed), 32'h00);
        tick(); exp_reg[1] = 16'hA5A4;
        chk_regs("pulse2_end"); chk("pulse2_end_changed", 32'(changed), 32'h00);

        // Out-of-range writes and read
        do_wr(3'd7, 2'd0, 16'h0000);
        chk_regs("oor7"); chk("oor7_changed", 32'(changed), 32'h00);
        do_wr(3'd6, 2'd3, 16'hFFFF);
        chk_regs("oor6"); chk("oor6_changed", 32'(changed), 32'h00);
        issue_rd(3'd6, 16'h0000);
        tick(); rd_en = 1'b0;

        // Back-to-back reads over the whole address space
        for (int a = 0; a < 8; a++) begin
            issue_rd(3'(a), (a < 6) ? exp_reg[a] : 16'h0000);
            tick();
        end
        issue_rd(3'd3, 16'h5554);
        tick(); rd_en = 1'b0;
        tick();
        chk("rd_hold", 32'(rd_data), 32'h5554);

        // Reset arriving in the middle of a read stream
        for (int a = 0; a < 8; a++) begin
            if (a == 3) Aclr = 1'b1;
            issue_rd(3'(a), (a < 6) ? exp_reg[a] : 16'h0000);
            tick();
            if (a == 3) begin
                chk("midrst_rd_data", 32'(rd_data), 32'd0);
                break;
            end
        end
        Aclr = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 6; i++) exp_reg[i] = 16'hA5A4;
        chk_regs("midrst");
        chk("midrst_changed", 32'(changed), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
